// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between two requesters:
//   port 0 : core datapath load/store (memory stage)
//   port 1 : host loader / debug access
//
// Every access is carried through the same fixed sequence:
//   IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> ACK -> IDLE
// so latency is fixed and independent of which port owns the memory.
// When both ports request in the same IDLE cycle, the port that was not
// served last wins. Under continuous contention the grants therefore
// alternate, and a port waits behind at most one foreign transaction.
//
// Parameters:
//   ADDR_W  - address width of both requesters and the memory
//   DATA_W  - data word width
//   MEM_LAT - memory read latency in cycles (1..4)
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_req0/1       level request; held with we/addr/wdata until ack
//   i_we0/1        1 = store, 0 = load
//   i_addr0/1      requester address
//   i_wdata0/1     requester store data
//   o_ack0/1       one-cycle completion pulse
//   o_rdata0/1     per-port load data, valid with ack, held otherwise
//   o_stall0/1     request pending (req & ~ack), holds the core PC
//   o_mem_en       one-cycle memory access strobe
//   o_mem_we       memory write enable, only asserted with o_mem_en
//   o_mem_addr     memory address, held until the next grant
//   o_mem_wdata    memory write data, held until the next grant
//   i_mem_rdata    memory read data, valid MEM_LAT cycles after o_mem_en
//   o_grant_id     port currently owning the memory
//   o_busy         sequencer is not idle
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 128,
  parameter int MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,

  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_ack0,
  output logic [DATA_W-1:0] o_rdata0,
  output logic              o_stall0,

  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_stall1,

  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,

  output logic              o_grant_id,
  output logic              o_busy
);

  // Two bits cover the whole supported latency range (MEM_LAT-1 = 0..3).
  localparam int               CNT_W    = 2;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;

  logic                r_lastGrant;
  logic                r_grantId;
  logic                r_memWe;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [DATA_W-1:0]   r_memWdata;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic [CNT_W-1:0]    r_waitCnt;

  logic                w_anyReq;
  logic                w_selPort;
  logic                w_waitDone;
  logic                w_memEn;
  logic                w_memWe;
  logic                w_ack0;
  logic                w_ack1;
  logic                w_busy;

  // Arbitration decision for the current IDLE cycle. A lone requester
  // always wins; on a tie the port that was not served last goes first,
  // which is what produces strict alternation under contention.
  always_comb begin
    w_anyReq   = i_req0 | i_req1;
    w_selPort  = (i_req0 & i_req1) ? ~r_lastGrant : i_req1;
    w_waitDone = (r_waitCnt == '0);
  end

  // Sequencer state register. Reset aborts any transaction in flight
  // straight back to IDLE; no ack is ever issued for an aborted access.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and per-state strobes. The memory strobe and the acks are
  // decoded straight from the state so each lasts exactly one cycle and
  // drops the instant reset is applied.
  always_comb begin
    w_stateNext = r_state;
    w_memEn     = 1'b0;
    w_memWe     = 1'b0;
    w_ack0      = 1'b0;
    w_ack1      = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_anyReq) begin
          w_stateNext = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_memEn     = 1'b1;
        w_memWe     = r_memWe;
        w_stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_waitDone) begin
          w_stateNext = ST_ACK;
        end
      end
      ST_ACK: begin
        w_ack0      = ~r_grantId;
        w_ack1      = r_grantId;
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping and the memory-side request registers. The winner's
  // command is captured once in IDLE so the memory sees a stable address
  // and data for the whole access, and those values are left in place
  // until the next grant. The wait counter is loaded in ACCESS and
  // counted down in WAIT; last_grant only moves once the access completes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lastGrant <= 1'b1;
      r_grantId   <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_waitCnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_anyReq) begin
            r_grantId  <= w_selPort;
            r_memWe    <= w_selPort ? i_we1    : i_we0;
            r_memAddr  <= w_selPort ? i_addr1  : i_addr0;
            r_memWdata <= w_selPort ? i_wdata1 : i_wdata0;
          end
        end
        ST_ACCESS: begin
          r_waitCnt <= LAT_LOAD;
        end
        ST_WAIT: begin
          if (!w_waitDone) begin
            r_waitCnt <= r_waitCnt - 1'b1;
          end
        end
        ST_ACK: begin
          r_lastGrant <= r_grantId;
        end
        default: begin
        end
      endcase
    end
  end

  // Read-data return. Memory data is captured on the last WAIT cycle into
  // the owning port's register only, and only for loads, so each port's
  // rdata keeps its last load result across stores and across the other
  // port's traffic.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if ((r_state == ST_WAIT) && w_waitDone && !r_memWe) begin
      if (r_grantId) begin
        r_rdata1 <= i_mem_rdata;
      end else begin
        r_rdata0 <= i_mem_rdata;
      end
    end
  end

  // Stall is purely combinational so the core PC holds in the very cycle
  // the request is raised and releases in the ack cycle.
  assign o_stall0    = i_req0 & ~w_ack0;
  assign o_stall1    = i_req1 & ~w_ack1;

  assign o_ack0      = w_ack0;
  assign o_ack1      = w_ack1;
  assign o_rdata0    = r_rdata0;
  assign o_rdata1    = r_rdata1;

  assign o_mem_en    = w_memEn;
  assign o_mem_we    = w_memWe;
  assign o_mem_addr  = r_memAddr;
  assign o_mem_wdata = r_memWdata;

  assign o_grant_id  = r_grantId;
  assign o_busy      = w_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Two arbiter instances: dutA with MEM_LAT=1 (main directed scenarios) and
// dutB with MEM_LAT=3 (latency scenario). Stimulus pushes the expected
// memory strobes and acks into queues; independent monitors pop and
// compare whenever the DUT presents mem_en or an ack.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  typedef struct {
    logic         port;
    logic [127:0] rdata;
    int           cyc;
  } ackExp_t;

  typedef struct {
    logic         port;
    logic         we;
    logic [17:0]  addr;
    logic [127:0] wdata;
    int           cyc;
  } memExp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  ackExp_t ackQA[$];
  ackExp_t ackQB[$];
  memExp_t memQA[$];

  // dutA signals
  logic         aReq0, aWe0, aReq1, aWe1;
  logic [17:0]  aAddr0, aAddr1;
  logic [127:0] aWdata0, aWdata1;
  logic         aAck0, aAck1, aStall0, aStall1;
  logic [127:0] aRdata0, aRdata1;
  logic         aMemEn, aMemWe, aGrantId, aBusy;
  logic [17:0]  aMemAddr;
  logic [127:0] aMemWdata, aMemRdata;

  // dutB signals
  logic         bReq0, bWe0, bReq1, bWe1;
  logic [17:0]  bAddr0, bAddr1;
  logic [127:0] bWdata0, bWdata1;
  logic         bAck0, bAck1, bStall0, bStall1;
  logic [127:0] bRdata0, bRdata1;
  logic         bMemEn, bMemWe, bGrantId, bBusy;
  logic [17:0]  bMemAddr;
  logic [127:0] bMemWdata, bMemRdata;

  // memory model state for dutA
  logic         prevEnA;
  logic [17:0]  prevAddrA;

  dmem_arbiter #(.ADDR_W(18), .DATA_W(128), .MEM_LAT(1)) dutA (
    .i_clk(clk), .i_reset(reset),
    .i_req0(aReq0), .i_we0(aWe0), .i_addr0(aAddr0), .i_wdata0(aWdata0),
    .o_ack0(aAck0), .o_rdata0(aRdata0), .o_stall0(aStall0),
    .i_req1(aReq1), .i_we1(aWe1), .i_addr1(aAddr1), .i_wdata1(aWdata1),
    .o_ack1(aAck1), .o_rdata1(aRdata1), .o_stall1(aStall1),
    .o_mem_en(aMemEn), .o_mem_we(aMemWe), .o_mem_addr(aMemAddr),
    .o_mem_wdata(aMemWdata), .i_mem_rdata(aMemRdata),
    .o_grant_id(aGrantId), .o_busy(aBusy)
  );

  dmem_arbiter #(.ADDR_W(18), .DATA_W(128), .MEM_LAT(3)) dutB (
    .i_clk(clk), .i_reset(reset),
    .i_req0(bReq0), .i_we0(bWe0), .i_addr0(bAddr0), .i_wdata0(bWdata0),
    .o_ack0(bAck0), .o_rdata0(bRdata0), .o_stall0(bStall0),
    .i_req1(bReq1), .i_we1(bWe1), .i_addr1(bAddr1), .i_wdata1(bWdata1),
    .o_ack1(bAck1), .o_rdata1(bRdata1), .o_stall1(bStall1),
    .o_mem_en(bMemEn), .o_mem_we(bMemWe), .o_mem_addr(bMemAddr),
    .o_mem_wdata(bMemWdata), .i_mem_rdata(bMemRdata),
    .o_grant_id(bGrantId), .o_busy(bBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Fixed memory contents seen by dutA.
  function automatic logic [127:0] memLookup(input logic [17:0] a);
    case (a)
      18'h00010: memLookup = 128'hA5;
      18'h00020: memLookup = 128'h1111;
      18'h00030: memLookup = 128'h2222;
      default:   memLookup = 128'hFFFF_0000;
    endcase
  endfunction

  // Latency-1 memory for dutA: data is valid only in the cycle after
  // mem_en, junk otherwise, so a mistimed capture shows up.
  initial begin
    prevEnA   = 1'b0;
    prevAddrA = '0;
    aMemRdata = 128'hBAD;
  end
  always @(negedge clk) begin
    aMemRdata = prevEnA ? memLookup(prevAddrA) : 128'hBAD;
    prevEnA   = aMemEn;
    prevAddrA = aMemAddr;
  end

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic port, input logic req, input logic we,
                               input logic [17:0] addr, input logic [127:0] wdata);
    if (port) begin
      aReq1 = req; aWe1 = we; aAddr1 = addr; aWdata1 = wdata;
    end else begin
      aReq0 = req; aWe0 = we; aAddr0 = addr; aWdata0 = wdata;
    end
  endtask

  task automatic pushAck(input logic port, input logic [127:0] rdata, input int c);
    ackExp_t e;
    e.port = port; e.rdata = rdata; e.cyc = c;
    ackQA.push_back(e);
  endtask

  task automatic pushMem(input logic port, input logic we, input logic [17:0] addr,
                         input logic [127:0] wdata, input int c);
    memExp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.cyc = c;
    memQA.push_back(e);
  endtask

  // One isolated transaction on dutA, requester drops req after ack.
  task automatic doTxn(input logic port, input logic we, input logic [17:0] addr,
                       input logic [127:0] wdata, input logic [127:0] expRdata);
    int c0;
    c0 = cyc;
    applyStimulus(port, 1'b1, we, addr, wdata);
    pushMem(port, we, addr, wdata, c0 + 1);
    pushAck(port, expRdata, c0 + 3);
    repeat (4) nextCycle();
    applyStimulus(port, 1'b0, 1'b0, 18'h0, 128'h0);
    nextCycle();
  endtask

  // Memory-side monitor for dutA.
  always @(negedge clk) begin
    memExp_t m;
    if (aMemEn) begin
      if (memQA.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL memA_unexpected: got mem_en=1 at cycle %0d, expected no access", cyc);
      end else begin
        m = memQA.pop_front();
        checkOutput("memA_cycle", 128'(cyc), 128'(m.cyc));
        checkOutput("memA_grant", 128'(aGrantId), 128'(m.port));
        checkOutput("memA_we", 128'(aMemWe), 128'(m.we));
        checkOutput("memA_addr", 128'(aMemAddr), 128'(m.addr));
        checkOutput("memA_wdata", aMemWdata, m.wdata);
      end
    end
  end

  // Ack monitor for dutA.
  always @(negedge clk) begin
    ackExp_t e;
    if (aAck0 || aAck1) begin
      if (ackQA.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL ackA_unexpected: got ack0=%0b ack1=%0b at cycle %0d, expected none",
                 aAck0, aAck1, cyc);
      end else begin
        e = ackQA.pop_front();
        checkOutput("ackA_port", 128'({aAck1, aAck0}), e.port ? 128'd2 : 128'd1);
        checkOutput("ackA_cycle", 128'(cyc), 128'(e.cyc));
        checkOutput("ackA_rdata", e.port ? aRdata1 : aRdata0, e.rdata);
      end
    end
  end

  // Ack monitor for dutB.
  always @(negedge clk) begin
    ackExp_t e;
    if (bAck0 || bAck1) begin
      if (ackQB.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL ackB_unexpected: got ack0=%0b ack1=%0b at cycle %0d, expected none",
                 bAck0, bAck1, cyc);
      end else begin
        e = ackQB.pop_front();
        checkOutput("ackB_port", 128'({bAck1, bAck0}), e.port ? 128'd2 : 128'd1);
        checkOutput("ackB_cycle", 128'(cyc), 128'(e.cyc));
        checkOutput("ackB_rdata", e.port ? bRdata1 : bRdata0, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c0;
    ackExp_t eb;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    aReq0 = 0; aWe0 = 0; aAddr0 = '0; aWdata0 = '0;
    aReq1 = 0; aWe1 = 0; aAddr1 = '0; aWdata1 = '0;
    bReq0 = 0; bWe0 = 0; bAddr0 = '0; bWdata0 = '0;
    bReq1 = 0; bWe1 = 0; bAddr1 = '0; bWdata1 = '0;
    bMemRdata = 128'h0BAD;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ctrlA", 128'({aAck0, aAck1, aMemEn, aMemWe, aGrantId, aBusy, aStall0, aStall1}), 128'd0);
    checkOutput("rst_rdata0A", aRdata0, 128'd0);
    checkOutput("rst_rdata1A", aRdata1, 128'd0);
    checkOutput("rst_memAddrA", 128'(aMemAddr), 128'd0);
    checkOutput("rst_memWdataA", aMemWdata, 128'd0);
    checkOutput("rst_ctrlB", 128'({bAck0, bAck1, bMemEn, bMemWe, bGrantId, bBusy}), 128'd0);
    aReq0 = 1'b1;
    #1;
    checkOutput("rst_stall0_comb", 128'(aStall0), 128'd1);
    aReq0 = 1'b0;
    nextCycle();
    reset = 1'b0;
    nextCycle();

    // Simultaneous requests after reset: port 0 first, then port 1
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 18'h00020, 128'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 18'h00030, 128'h1);
    pushMem(1'b0, 1'b0, 18'h00020, 128'h0, c0 + 1);
    pushAck(1'b0, 128'h1111, c0 + 3);
    pushMem(1'b1, 1'b0, 18'h00030, 128'h1, c0 + 5);
    pushAck(1'b1, 128'h2222, c0 + 7);
    repeat (4) nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 128'h0);
    repeat (4) nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 128'h0);
    nextCycle();

    // Single read on port 0 with stall/busy timing
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 18'h00010, 128'h0);
    pushMem(1'b0, 1'b0, 18'h00010, 128'h0, c0 + 1);
    pushAck(1'b0, 128'hA5, c0 + 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("read_stall0", 128'(aStall0), (i < 3) ? 128'd1 : 128'd0);
      checkOutput("read_busy", 128'(aBusy), (i > 0) ? 128'd1 : 128'd0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 128'h0);
    nextCycle();

    // Store on port 0: rdata0 keeps the earlier load value
    doTxn(1'b0, 1'b1, 18'h00040, 128'hBEEF, 128'hA5);

    // Store on port 1 at top address: rdata1 keeps its earlier load value
    doTxn(1'b1, 1'b1, 18'h3FFFF, 128'hDEAD, 128'h2222);

    // Continuous contention: eight alternating grants starting with port 0
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 18'h00010, 128'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 18'h00020, 128'h0);
    for (int k = 0; k < 8; k++) begin
      pushMem(k[0], 1'b0, k[0] ? 18'h00020 : 18'h00010, 128'h0, c0 + 1 + 4 * k);
      pushAck(k[0], k[0] ? 128'h1111 : 128'hA5, c0 + 3 + 4 * k);
    end
    repeat (32) nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 128'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 128'h0);
    nextCycle();

    // Reset during WAIT: access issued, no ack, everything idles at once
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 18'h00030, 128'h0);
    pushMem(1'b0, 1'b0, 18'h00030, 128'h0, c0 + 1);
    repeat (2) nextCycle();
    reset = 1'b1;
    #1;
    checkOutput("midrst_ctrl", 128'({aAck0, aAck1, aBusy, aMemEn, aGrantId}), 128'd0);
    checkOutput("midrst_rdata0", aRdata0, 128'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 128'h0);
    nextCycle();
    reset = 1'b0;
    doTxn(1'b1, 1'b0, 18'h00020, 128'h0, 128'h1111);

    // MEM_LAT=3 on dutB: mem_en at +1, data sampled at +4, ack at +5
    c0 = cyc;
    bReq0 = 1'b1; bWe0 = 1'b0; bAddr0 = 18'h00055; bWdata0 = 128'h0;
    eb.port = 1'b0; eb.rdata = 128'hCAFE; eb.cyc = c0 + 5;
    ackQB.push_back(eb);
    for (int i = 1; i <= 6; i++) begin
      nextCycle();
      bMemRdata = (i == 4) ? 128'hCAFE : (128'h0BAD0 + 128'(i));
      if (i == 6) bReq0 = 1'b0;
      @(negedge clk);
      checkOutput("lat3_mem_en", 128'(bMemEn), (i == 1) ? 128'd1 : 128'd0);
      if (i == 1) checkOutput("lat3_mem_addr", 128'(bMemAddr), 128'h55);
    end

    repeat (3) nextCycle();
    checkOutput("ackQA_drained", 128'(ackQA.size()), 128'd0);
    checkOutput("memQA_drained", 128'(memQA.size()), 128'd0);
    checkOutput("ackQB_drained", 128'(ackQB.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 128-bit data memory between two requesters: port 0 (core datapath load/store) and port 1 (host loader/debug).
- Sequences every access through a fixed request/grant/access/ack cycle with round-robin fairness.
- Drives a per-port stall so the core's PC flip-flop holds while its access is pending.
- Sits between the datapath's memory stage and data memory.

Parameters:
- ADDR_W, 18, address width of requesters and memory.
- DATA_W, 128, data word width.
- MEM_LAT, 1, memory read latency in cycles, range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request, level.
- we0  in  1  port 0 write enable (1 = store).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 completion pulse, one cycle.
- rdata0  out  DATA_W  port 0 read data, valid when ack0=1.
- stall0  out  1  port 0 pending: req0 & ~ack0.
- req1, we1, addr1, wdata1, ack1, rdata1, stall1: same as port 0, for port 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- grant_id  out  1  port currently owning the memory.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, active-high):
  - State = IDLE; last_grant = 1, so port 0 wins the first tie.
  - All outputs 0: ack*, rdata*, mem_en, mem_we, mem_addr, mem_wdata, grant_id, busy.
  - stall* follows its combinational definition.
- Requester rule: hold req, we, addr and wdata stable until ack; deassert req the cycle after ack.
- FSM states: IDLE, ACCESS, WAIT, ACK.
  - IDLE:
    - If any req is high, select a port. A single requester wins. If both request, the port != last_grant wins.
    - Latch the selected port's we/addr/wdata into the mem_* registers and set grant_id.
    - Next state ACCESS.
  - ACCESS: mem_en=1 for exactly one cycle, mem_we=latched we. Load the wait counter with MEM_LAT-1. Next state WAIT.
  - WAIT:
    - mem_en=0. Decrement the counter.
    - When the counter is 0, capture mem_rdata into the granted port's rdata register. Next state ACK.
    - With MEM_LAT=1, WAIT lasts one cycle.
  - ACK:
    - Granted port's ack=1 for one cycle. Update last_grant = grant_id. Next state IDLE.
    - A req still high in the following IDLE cycle is a new request.
- Latency: req high in IDLE at cycle t → mem_en at t+1 → ack at t+2+MEM_LAT. With MEM_LAT=1, ack is at t+3.
- Throughput: one access per MEM_LAT+3 cycles.
- Writes follow the same sequence and latency. rdata is not updated on writes and holds its previous value.
- The non-granted port's rdata holds its value across the other port's transactions.
- busy=1 in ACCESS, WAIT and ACK.
- mem_addr and mem_wdata hold until the next grant.
- Fairness: under continuous requests from both ports, grants alternate 0,1,0,1. Maximum wait per port is one foreign transaction.
- Boundary cases:
  - A requester dropping req before ack is a protocol violation. The transaction still completes and ack still pulses.
  - A new req arriving during ACCESS/WAIT/ACK is ignored until IDLE.
  - Reset asserted mid-transaction aborts immediately to the reset state. An issued mem_en is not retracted, and no ack is given.
  - Address/data widths pass through unmodified; there is no address decoding.

Test Plan:
- Single read: reset, MEM_LAT=1, req0=1, we0=0, addr0=0x00010, mem_rdata returns 128'hA5 → mem_en at cycle 1 with mem_addr=0x00010 → ack0 at cycle 3 with rdata0=128'hA5; stall0 high in cycles 0-2.
- Single write: req1=1, we1=1, addr1=0x3FFFF, wdata1=128'hDEAD → mem_we=1 and mem_wdata=128'hDEAD with mem_en at cycle 1 → ack1 at cycle 3; rdata1 unchanged.
- Simultaneous after reset: req0=req1=1 at cycle 0 → port 0 granted first (ack0 at cycle 3) → port 1 granted in IDLE cycle 4 (ack1 at cycle 7).
- Continuous contention: both ports requesting for 8 transactions → grant_id sequence 0,1,0,1,0,1,0,1; never two consecutive grants to one port.
- Latency parameter: MEM_LAT=3, read request at cycle 0 → mem_en at cycle 1 → ack at cycle 5; rdata equals the mem_rdata presented at cycle 4.
- Reset mid-op: assert reset during WAIT → ack0/ack1, busy and mem_en go 0 immediately. After release, req1 alone is granted normally, with ack1 three cycles after IDLE sampling.
